// File: rtl/window_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : window_gen_pkg                                                  |
// | Purpose  : Shared pixel/row widths and row packing for the 3x3 window      |
// |            generator and the convolution MAC that consumes its rows.       |
// | Contents : PIX_W, ROW_W, pix_t, row_t, pack_row()                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package window_gen_pkg;

   localparam int PIX_W = 13;
   localparam int ROW_W = 3 * PIX_W;

   typedef logic signed [PIX_W-1:0] pix_t;
   typedef logic        [ROW_W-1:0] row_t;

   // Newest column lives in the top field, oldest in the bottom field.
   function automatic row_t pack_row(input logic [PIX_W-1:0] col_c,
                                     input logic [PIX_W-1:0] col_c1,
                                     input logic [PIX_W-1:0] col_c2);
      return {col_c, col_c1, col_c2};
   endfunction

endpackage
`default_nettype wire

// File: rtl/window_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : window_gen_if                                                   |
// | Purpose  : Pixel-in / window-out bundle of the 3x3 window generator.       |
// | Signals  : pix_in, pix_valid       (source -> generator)                   |
// |            row1, row2, row3,                                               |
// |            win_valid, frame_done   (generator -> MAC)                      |
// | Modports : master = pixel source side, slave = window generator side       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface window_gen_if;
   import window_gen_pkg::*;

   logic [PIX_W-1:0] pix_in;
   logic             pix_valid;
   logic [ROW_W-1:0] row1;
   logic [ROW_W-1:0] row2;
   logic [ROW_W-1:0] row3;
   logic             win_valid;
   logic             frame_done;

   modport master (
      output pix_in, pix_valid,
      input  row1, row2, row3, win_valid, frame_done
   );

   modport slave (
      input  pix_in, pix_valid,
      output row1, row2, row3, win_valid, frame_done
   );

endinterface
`default_nettype wire

// File: rtl/window_gen_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : line_buffer                                                     |
// | Purpose  : Enable-gated shift register; dout is din delayed by DEPTH       |
// |            enabled cycles (one image line when DEPTH = image width).       |
// | Ports    : clk  - clock                                                    |
// |            en   - shift enable (accepted pixel)                            |
// |            din  - data in                                                  |
// |            dout - data from DEPTH enables ago                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module line_buffer #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [DEPTH-1:0][WIDTH-1:0] sr_q;
   logic [DEPTH-1:0][WIDTH-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (en) begin
         sr_d = {sr_q[DEPTH-2:0], din};
      end
   end

   // Contents are never observable before two full lines have been written,
   // so the storage carries no reset.
   always_ff @(posedge clk) begin
      sr_q <= sr_d;
   end

   assign dout = sr_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/window_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : window_gen                                                      |
// | Purpose  : Streaming 3x3 window generator. Buffers two image lines and     |
// |            presents each interior 3x3 neighbourhood as three packed rows.  |
// | Ports    : clk - clock, rst - asynchronous active-high reset               |
// |            bus - window_gen_if.slave (pix_in, pix_valid, row1..row3,       |
// |                  win_valid, frame_done)                                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module window_gen
   import window_gen_pkg::*;
#(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic        clk,
   input  logic        rst,
   window_gen_if.slave bus
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROWC_W = $clog2(IMG_H);
   localparam logic [COL_W-1:0]  C_COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROWC_W-1:0] C_ROW_LAST = ROWC_W'(IMG_H - 1);

   logic [COL_W-1:0]  col_q, col_d;
   logic [ROWC_W-1:0] row_q, row_d;
   row_t              row1_q, row1_d;
   row_t              row2_q, row2_d;
   row_t              row3_q, row3_d;
   logic              win_valid_q, win_valid_d;
   logic              frame_done_q, frame_done_d;

   logic [PIX_W-1:0]  lb0_dout;
   logic [PIX_W-1:0]  lb1_dout;
   logic              last_col;
   logic              last_row;

   // lb0 yields the pixel one line above the incoming one, lb1 two lines above.
   line_buffer #(.WIDTH(PIX_W), .DEPTH(IMG_W)) u_lb0 (
      .clk  (clk),
      .en   (bus.pix_valid),
      .din  (bus.pix_in),
      .dout (lb0_dout)
   );

   line_buffer #(.WIDTH(PIX_W), .DEPTH(IMG_W)) u_lb1 (
      .clk  (clk),
      .en   (bus.pix_valid),
      .din  (lb0_dout),
      .dout (lb1_dout)
   );

   assign last_col = (col_q == C_COL_LAST);
   assign last_row = (row_q == C_ROW_LAST);

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      row1_d       = row1_q;
      row2_d       = row2_q;
      row3_d       = row3_q;
      win_valid_d  = 1'b0;
      frame_done_d = 1'b0;

      if (bus.pix_valid) begin
         // Shift every row one column left; the new column enters at the top field.
         row3_d = pack_row(bus.pix_in, row3_q[ROW_W-1 -: PIX_W], row3_q[2*PIX_W-1 -: PIX_W]);
         row2_d = pack_row(lb0_dout,   row2_q[ROW_W-1 -: PIX_W], row2_q[2*PIX_W-1 -: PIX_W]);
         row1_d = pack_row(lb1_dout,   row1_q[ROW_W-1 -: PIX_W], row1_q[2*PIX_W-1 -: PIX_W]);

         // The row gate masks stale line-buffer data (new frame or after reset);
         // the col gate drops the two columns left over from the previous line.
         win_valid_d  = (row_q >= ROWC_W'(2)) && (col_q >= COL_W'(2));
         frame_done_d = last_col && last_row;

         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + ROWC_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         row1_q       <= '0;
         row2_q       <= '0;
         row3_q       <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         row1_q       <= row1_d;
         row2_q       <= row2_d;
         row3_q       <= row3_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.row1       = row1_q;
   assign bus.row2       = row2_q;
   assign bus.row3       = row3_q;
   assign bus.win_valid  = win_valid_q;
   assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_window_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_window_gen                                                   |
// | Purpose  : Self-checking vector bench for window_gen on a 4x4 image.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_window_gen;

   localparam int W = 4;
   localparam int H = 4;
   localparam int NPIX = W * H;

   typedef struct {
      logic [12:0] pix;
      logic        valid;
      logic        exp_wv;
      logic        exp_fd;
      logic        chk_rows;
      logic [38:0] e1;
      logic [38:0] e2;
      logic [38:0] e3;
      logic [12:0] e_top;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   window_gen_if bus ();

   window_gen #(.IMG_W(W), .IMG_H(H)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   vec_t        vecs[$];
   logic [12:0] vals[NPIX];
   logic [12:0] last_pix = 13'd0;
   int          n_vec = 0;
   int          n_bad = 0;
   int          vec_idx = 0;

   function automatic logic [38:0] pk(input logic [12:0] c, input logic [12:0] c1,
                                      input logic [12:0] c2);
      return {c, c1, c2};
   endfunction

   task automatic chk(input string nm, input logic [38:0] act, input logic [38:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s vec %0d: got %h expected %h", nm, vec_idx, act, exp);
      end
   endtask

   // Queue n pixels of vals[] as a frame starting at (0,0), each followed by gap idle cycles.
   task automatic add_frame(input int n, input int gap);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v.pix      = vals[i];
         v.valid    = 1'b1;
         v.exp_wv   = ((i / W) >= 2) && ((i % W) >= 2);
         v.exp_fd   = (i == NPIX - 1);
         v.chk_rows = v.exp_wv;
         v.e1 = '0; v.e2 = '0; v.e3 = '0;
         if (v.exp_wv) begin
            v.e3 = pk(vals[i],         vals[i-1],         vals[i-2]);
            v.e2 = pk(vals[i-W],       vals[i-W-1],       vals[i-W-2]);
            v.e1 = pk(vals[i-2*W],     vals[i-2*W-1],     vals[i-2*W-2]);
         end
         v.e_top  = vals[i];
         last_pix = vals[i];
         vecs.push_back(v);
         for (int g = 0; g < gap; g++) begin
            v.pix    = 13'h0AAA;
            v.valid  = 1'b0;
            v.exp_wv = 1'b0;
            v.exp_fd = 1'b0;
            vecs.push_back(v);
         end
      end
   endtask

   task automatic add_idle_zero(input int n);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v.pix = 13'h1555; v.valid = 1'b0; v.exp_wv = 1'b0; v.exp_fd = 1'b0;
         v.chk_rows = 1'b1; v.e1 = '0; v.e2 = '0; v.e3 = '0; v.e_top = 13'd0;
         vecs.push_back(v);
      end
   endtask

   task automatic run();
      vec_t v;
      while (vecs.size() > 0) begin
         v = vecs.pop_front();
         @(negedge clk);
         bus.pix_in    = v.pix;
         bus.pix_valid = v.valid;
         @(posedge clk);
         #1;
         n_vec++;
         chk("win_valid",  {38'd0, bus.win_valid},  {38'd0, v.exp_wv});
         chk("frame_done", {38'd0, bus.frame_done}, {38'd0, v.exp_fd});
         chk("row3_top",   {26'd0, bus.row3[38:26]}, {26'd0, v.e_top});
         if (v.chk_rows) begin
            chk("row1", bus.row1, v.e1);
            chk("row2", bus.row2, v.e2);
            chk("row3", bus.row3, v.e3);
         end
         vec_idx++;
      end
   endtask

   task automatic set_ramp(input int base);
      for (int i = 0; i < NPIX; i++) vals[i] = 13'(base + i);
   endtask

   initial begin
      bus.pix_in    = '0;
      bus.pix_valid = 1'b0;

      // Reset state, held while idle.
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      add_idle_zero(4);
      run();

      // Back-to-back 0..15: windows at pixels 10, 11, 14, 15.
      set_ramp(0);
      add_frame(NPIX, 0);
      run();

      // Same frame with 3 idle cycles after every pixel; rows must hold in gaps.
      add_frame(NPIX, 3);
      run();

      // Extreme negative values pass bit-exact.
      for (int i = 0; i < NPIX; i++) vals[i] = 13'(i * 37 - 300);
      vals[5]  = 13'h1FFF;
      vals[10] = 13'h1000;
      add_frame(NPIX, 0);
      run();

      // Two frames back-to-back; second frame's stale lines must stay masked.
      set_ramp(0);
      add_frame(NPIX, 0);
      run();
      set_ramp(100);
      add_frame(NPIX, 0);
      run();

      // Hand-checked first window of the 100..115 frame already applied above;
      // confirm its constant values independently on a replay.
      set_ramp(100);
      add_frame(11, 0);
      while (vecs.size() > 0) begin
         if (vecs.size() == 1) break;
         void'(vecs.pop_front());
      end
      // Drive pixels 100..109 plainly, then check pixel 110 against constants.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.pix_in = 13'(100 + i);
         bus.pix_valid = 1'b1;
      end
      vecs.delete();
      @(negedge clk);
      bus.pix_in = 13'd110;
      @(posedge clk);
      #1;
      n_vec++;
      chk("hand_row1", bus.row1, {13'd102, 13'd101, 13'd100});
      chk("hand_row2", bus.row2, {13'd106, 13'd105, 13'd104});
      chk("hand_row3", bus.row3, {13'd110, 13'd109, 13'd108});
      chk("hand_wv",   {38'd0, bus.win_valid}, 39'd1);
      vec_idx++;
      // Finish that frame so the counters sit at (0,0) again.
      for (int i = 11; i < NPIX; i++) begin
         @(negedge clk);
         bus.pix_in = 13'(100 + i);
      end
      @(negedge clk);
      bus.pix_valid = 1'b0;

      // Reset after pixel 9 of a frame, then a fresh frame.
      set_ramp(0);
      add_frame(10, 0);
      run();
      @(negedge clk);
      bus.pix_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_vec++;
      chk("rst_wv",   {38'd0, bus.win_valid},  39'd0);
      chk("rst_fd",   {38'd0, bus.frame_done}, 39'd0);
      chk("rst_row1", bus.row1, 39'd0);
      chk("rst_row2", bus.row2, 39'd0);
      chk("rst_row3", bus.row3, 39'd0);
      vec_idx++;
      @(negedge clk);
      rst = 1'b0;
      add_frame(NPIX, 0);
      run();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
